// File: rtl/mac_pkg.sv
// Constants and types shared by the MAC array and its result drain.
package mac_pkg;
  localparam int DATA_W = 8;
  localparam int MUL_W  = 16;
  localparam int ACC_W  = 32;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int OUT_W  = 8;

  typedef enum logic {IDLE, DRAIN} drain_state_e;
endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, then saturate to OUT_W signed.
module requant_sat #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   q,
  output logic               sat
);
  localparam logic signed [ACC_W:0] QMAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] QMIN = ~QMAX;

  logic [ACC_W:0]        rnd;
  logic signed [ACC_W:0] v, qf;

  // Half-LSB rounding constant; collapses to zero when shift is zero.
  assign rnd = ((ACC_W+1)'(1) << shift) >> 1;
  assign v   = $signed({acc[ACC_W-1], acc}) + $signed(rnd);
  assign qf  = v >>> shift;

  always_comb begin
    q   = qf[OUT_W-1:0];
    sat = 1'b0;
    if (qf > QMAX) begin
      q   = QMAX[OUT_W-1:0];
      sat = 1'b1;
    end else if (qf < QMIN) begin
      q   = QMIN[OUT_W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/mac_result_drain.sv
// Snapshots the MAC accumulators on start and streams requantized elements out row-major.
module mac_result_drain #(
  parameter int ROWS    = mac_pkg::ROWS,
  parameter int COLS    = mac_pkg::COLS,
  parameter int ACC_W   = mac_pkg::ACC_W,
  parameter int OUT_W   = mac_pkg::OUT_W,
  parameter int SHIFT_W = 5,
  localparam int N      = ROWS*COLS,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*ACC_W-1:0]   acc_flat,
  input  logic [SHIFT_W-1:0]   shift,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic                 out_sat,
  output logic                 done
);
  import mac_pkg::*;

  drain_state_e            state_q, state_d;
  logic [N-1:0][ACC_W-1:0] snap;
  logic [SHIFT_W-1:0]      shift_q;
  logic                    hs, load, adv, fin;
  logic [IDX_W-1:0]        nidx, next_idx;
  logic [ACC_W-1:0]        sel_acc;
  logic [SHIFT_W-1:0]      sel_shift;
  logic [OUT_W-1:0]        rq;
  logic                    rsat;

  assign hs       = out_valid & out_ready;
  assign nidx     = out_idx + IDX_W'(1);
  assign next_idx = load ? '0 : nidx;

  // Outputs are registered, so the requantizer always works on the element
  // about to be presented: element 0 straight from the array on capture,
  // otherwise the next snapshot entry.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    sel_acc   = snap[nidx];
    sel_shift = shift_q;
    case (state_q)
      IDLE: if (start) begin
        load      = 1'b1;
        state_d   = DRAIN;
        sel_acc   = acc_flat[ACC_W-1:0];
        sel_shift = shift;
      end
      DRAIN: if (hs) begin
        if (out_idx == IDX_W'(N-1)) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else begin
          adv = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  requant_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rq (
    .acc   (sel_acc),
    .shift (sel_shift),
    .q     (rq),
    .sat   (rsat)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap      <= '0;
      shift_q   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        snap    <= acc_flat;
        shift_q <= shift;
      end
      if (load | adv) begin
        busy      <= 1'b1;
        out_valid <= 1'b1;
        out_data  <= rq;
        out_sat   <= rsat;
        out_idx   <= next_idx;
        out_last  <= (next_idx == IDX_W'(N-1));
      end else if (fin) begin
        busy      <= 1'b0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_sat   <= 1'b0;
        out_idx   <= '0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: directed drains, backpressure, restart and reset cases.
module tb_mac_result_drain;
  localparam int MODE_NORM = 0, MODE_BP = 1, MODE_BUSY = 2, MODE_RST = 3;

  logic         clk = 0, rst = 1, start = 0, out_ready = 0;
  logic [511:0] acc_flat = '0;
  logic [4:0]   shift = '0;
  logic         busy, out_valid, out_last, out_sat, done;
  logic [7:0]   out_data;
  logic [3:0]   out_idx;

  typedef struct { int data; int idx; bit last; bit sat; } exp_t;
  exp_t sbq[$];
  int   accs[16];
  int   errors = 0, checks = 0, hs_cnt = 0, done_cnt = 0, ncyc;
  bit   prev_stall = 0, prev_last_hs = 0;
  logic [12:0] saved;

  mac_result_drain dut (
    .clk(clk), .rst(rst), .start(start), .acc_flat(acc_flat), .shift(shift),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input longint acc, input int sh, output int q, output bit s);
    longint v;
    v = acc + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
    v = v >>> sh;
    s = 1'b1;
    if (v > 127)       q = 127;
    else if (v < -128) q = -128;
    else begin q = int'(v); s = 1'b0; end
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Output monitor: pops the scoreboard on every handshake, checks stall stability and done timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall   = 0;
      prev_last_hs = 0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {out_valid, out_data, out_idx}, saved);
      if (done || prev_last_hs) chk("done_pulse", done, prev_last_hs);
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $error("FAIL sb_unexpected observed idx=%0d expected no beat", out_idx);
        end else begin
          e = sbq.pop_front();
          chk("data", $signed(out_data), e.data);
          chk("idx",  out_idx,  e.idx);
          chk("last", out_last, e.last);
          chk("sat",  out_sat,  e.sat);
        end
      end
      prev_stall   = out_valid && !out_ready;
      saved        = {out_valid, out_data, out_idx};
      prev_last_hs = out_valid && out_ready && out_last;
      if (done) done_cnt++;
    end
  end

  task automatic start_drain(input int sh);
    int q; bit s;
    for (int k = 0; k < 16; k++) begin
      acc_flat[k*32 +: 32] = accs[k];
      model(longint'(accs[k]), sh, q, s);
      sbq.push_back('{q, k, k == 15, s});
    end
    shift = 5'(sh);
    start = 1;
    cyc();
    start = 0;
    chk("cap_valid", out_valid, 1);
    chk("cap_busy",  busy,      1);
    chk("cap_idx",   out_idx,   0);
  endtask

  task automatic run(input int mode, output int n);
    int  hs0 = hs_cnt, d0 = done_cnt;
    bit  seen = 0, fired = 0;
    n = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (mode == MODE_BP) out_ready = ($urandom_range(0, 9) < 3);
      if (mode == MODE_BP && i == 10)
        for (int k = 0; k < 16; k++) acc_flat[k*32 +: 32] = $urandom;
      start = (mode == MODE_BUSY && !fired && out_valid && out_idx == 4'd5);
      if (start) fired = 1;
      if (mode == MODE_RST && out_valid && out_idx == 4'd7) begin
        rst = 1;
        cyc();
        chk("rst_outputs", {busy, out_valid, out_data, out_idx, out_last, out_sat, done}, 0);
        rst = 0;
        sbq.delete();
        repeat (4) cyc();
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle", busy, 0);
        return;
      end
      cyc();
      n++;
      seen = done;
    end
    start = 0;
    out_ready = 1;
    chk("done_seen", seen, 1);
    chk("done_cycle_idle", {busy, out_valid}, 0);
    #6;
    chk("hs_count",   hs_cnt - hs0, 16);
    chk("done_count", done_cnt - d0, 1);
    chk("sb_empty",   sbq.size(), 0);
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_outputs", {busy, out_valid, out_data, out_idx, out_last, out_sat, done}, 0);
    rst = 0;
    out_ready = 1;
    repeat (3) cyc();
    chk("idle_ready_noeffect", {busy, out_valid, done}, 0);

    // basic: acc=k, shift 0
    for (int k = 0; k < 16; k++) accs[k] = k;
    start_drain(0);
    run(MODE_NORM, ncyc);
    chk("throughput", ncyc, 16);

    // rounding with shift 1, then shift 3
    for (int k = 0; k < 16; k++) accs[k] = int'($urandom_range(0, 600)) - 300;
    accs[0] = 5; accs[1] = -5; accs[2] = 4; accs[3] = -1;
    start_drain(1);
    run(MODE_NORM, ncyc);
    accs[0] = -12; accs[1] = -13; accs[2] = 12; accs[3] = -3;
    start_drain(3);
    run(MODE_NORM, ncyc);

    // saturation boundaries
    for (int k = 0; k < 16; k++) accs[k] = int'($urandom);
    accs[0] = 1000; accs[1] = -1000; accs[2] = 508; accs[3] = 510; accs[4] = -514;
    start_drain(2);
    run(MODE_NORM, ncyc);
    accs[0] = -100000; accs[1] = 127; accs[2] = 128; accs[3] = -128; accs[4] = -129;
    start_drain(0);
    run(MODE_NORM, ncyc);
    start_drain(31);
    run(MODE_NORM, ncyc);

    // backpressure with a mid-drain change on acc_flat
    for (int k = 0; k < 16; k++) accs[k] = int'($urandom_range(0, 4000)) - 2000;
    start_drain(4);
    run(MODE_BP, ncyc);

    // start while busy, then start again in the done cycle
    for (int k = 0; k < 16; k++) accs[k] = 100 - 13 * k;
    start_drain(0);
    run(MODE_BUSY, ncyc);
    for (int k = 0; k < 16; k++) accs[k] = 7 * k - 50;
    start_drain(1);
    run(MODE_NORM, ncyc);

    // reset mid-drain, then a fresh drain from idx 0
    start_drain(0);
    run(MODE_RST, ncyc);
    for (int k = 0; k < 16; k++) accs[k] = -k;
    start_drain(0);
    run(MODE_NORM, ncyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Read-out engine for the 4x4 signed MAC array. On a start pulse it snapshots all ROWS*COLS accumulators, then streams them out one element per handshake in row-major order. Each 32-bit accumulator is requantized to signed 8 bits by a rounding arithmetic right shift followed by saturation. The array can clear and resume accumulating the cycle after start, while the drain streams results to the downstream buffer or DMA over a valid/ready interface.

## Interface
Parameters:
- ROWS, 4, array rows
- COLS, 4, array columns
- ACC_W, 32, accumulator width
- OUT_W, 8, requantized output width
- SHIFT_W, 5, width of the shift amount
- N derived = ROWS*COLS; IDX_W derived = $clog2(N)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to capture and drain
- acc_flat  in  N*ACC_W  signed accumulators; element k at [k*ACC_W +: ACC_W], k = r*COLS+c
- shift  in  SHIFT_W  right-shift amount, 0..ACC_W-1, sampled with start
- busy  out  1  high from capture until the last element is accepted
- out_valid  out  1  out_data, out_idx, out_last and out_sat are valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_data  out  OUT_W  signed requantized element
- out_idx  out  IDX_W  element index k
- out_last  out  1  high with element N-1
- out_sat  out  1  this element was clipped
- done  out  1  one-cycle pulse after the last handshake

## Operation
- States: IDLE, DRAIN. Reset enters IDLE. Every output resets to 0, and the index counter resets to 0.
- IDLE with start=1: register acc_flat and shift into a snapshot, set idx=0, go to DRAIN. Start is ignored in DRAIN.
- DRAIN: present element idx with out_valid=1.
  - Handshake (out_valid & out_ready) with idx<N-1: idx increments and the next element is presented on the following cycle.
  - Handshake with idx=N-1: go to IDLE, pulse done for one cycle, and deassert busy and out_valid.
- Requantization, computed at ACC_W+1 bits:
  - If shift>0, v = acc + (1<<(shift-1)); if shift=0, v = acc.
  - q = v >>> shift.
  - If q>2^(OUT_W-1)-1, output 127 with out_sat=1. If q<-2^(OUT_W-1), output -128 with out_sat=1. Otherwise output q with out_sat=0.
  - Rounding is round-half-up, toward +infinity.
- A shift value of ACC_W or more is out of range. The behaviour is undefined, and verification must not drive it.
- Snapshot contents are held until the next accepted start. Changes on acc_flat during DRAIN have no effect.

## Timing
- Capture latency: start high at edge t gives out_valid=1 and busy=1 from t+1, with element 0 presented.
- Output signals are registered. They hold stable while out_valid=1 and out_ready=0. out_valid never drops without a handshake, except on rst.
- Throughput: one element per cycle while out_ready is held high. N elements take N cycles from the first valid.
- done pulses in the cycle after the final handshake, together with busy=0. start is accepted again in that same cycle, with the capture taking effect on the next edge.
- rst during DRAIN: on the next edge the block returns to IDLE with all outputs 0. No done is generated, and the snapshot is discarded.
- out_ready high while out_valid=0 has no effect.

## Structure
- Shared package mac_pkg:
  - Constants: DATA_W=8, MUL_W=16, ACC_W=32, ROWS=4, COLS=4, OUT_W=8.
  - Typedef drain_state_e {IDLE, DRAIN}.
  - These are the same constants the MAC array uses.
- One sub-module, requant_sat: combinational round, shift and saturate, with outputs q[OUT_W-1:0] and sat. It is instantiated once on the muxed snapshot element. Its output is registered in mac_result_drain.

## Test plan
- Basic drain: elements k=0..15 with acc=k, shift=0, out_ready tied high. Expect 16 consecutive beats with out_data 0..15 and out_idx 0..15, out_last only on the beat with idx 15, done one cycle after that beat, and out_sat always 0.
- Rounding, shift=1:
  - acc=5 gives 3; acc=-5 gives -2; acc=4 gives 2.
  - acc=-1 gives 0; with shift=3, acc=-12 gives -1.
- Saturation:
  - acc=1000 with shift=2 gives 250, clipped to 127 with out_sat=1.
  - acc=-100000 with shift=0 gives -128 with out_sat=1.
  - acc=127 with shift=0 gives 127 with out_sat=0.
- Backpressure: random out_ready at 30% duty. Outputs stay stable during stalls, the order is preserved, and exactly 16 handshakes occur. Change acc_flat mid-drain; the output stream must be unaffected.
- start while busy: pulse start at element 5. Expect no restart, the index keeps incrementing, and a single done. Then start again in the done cycle; the new capture is accepted.
- Reset mid-drain: assert rst at element 7. Next cycle all outputs are 0 and the state is IDLE, with no done. A subsequent start drains from idx 0.
